router_fifo: RTL and testbench



---
 rtl/router_fifo.sv | 92 +++++++++
 tb/tb_router_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-port packet FIFO for the 1x3 router: stores header/payload/parity bytes and tracks packet length at the output.
// Optional sticky overflow flag enabled by defining ROUTER_FIFO_OVF_FLAG_EN.
module router_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef ROUTER_FIFO_OVF_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 6;

  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   pkt_cnt;
  logic [WIDTH:0]  rd_entry;
  logic            wr_acc;
  logic            rd_acc;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_acc   = write_enb && !full;
  assign rd_acc   = read_enb && !empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  // Storage is never cleared; a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && !soft_reset) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PW'(1);
        data_out <= rd_entry[WIDTH-1:0];
        // Header load covers the payload bytes plus the trailing parity byte.
        if (rd_entry[WIDTH]) begin
          pkt_cnt <= CW'(rd_entry[7:2]) + CW'(1);
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - CW'(1);
        end
      end else if (pkt_cnt == '0) begin
        data_out <= '0;
      end
    end
  end

`ifdef ROUTER_FIFO_OVF_FLAG_EN
  // Sticky record of any write attempted while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (soft_reset) begin
      overflow <= 1'b0;
    end else if (write_enb && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo; honours ROUTER_FIFO_OVF_FLAG_EN for the overflow port.
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef ROUTER_FIFO_OVF_FLAG_EN
  logic       overflow;
`endif

  int checks   = 0;
  int failures = 0;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_FIFO_OVF_FLAG_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic hdr);
    write_enb = 1'b1;
    lfd_state = hdr;
    data_in   = d;
    tick();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
`ifdef ROUTER_FIFO_OVF_FLAG_EN
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`endif
  endtask

  task automatic test_packet();
    logic [7:0] exp [5];
    exp = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h3F};
    wr(8'h0C, 1'b1);
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL pkt_empty_after_hdr got=%b exp=0", empty); end
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    wr(8'h3F, 1'b0);
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (data_out !== exp[i]) begin failures++; $display("FAIL pkt_read%0d got=%h exp=%h", i, data_out, exp[i]); end
    end
    read_enb = 1'b0;
    tick();
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL pkt_idle_data got=%h exp=00", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pkt_idle_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      wr(8'hA0 + 8'(i), 1'b0);
      if (i == 14) begin
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_at15 got=%b exp=0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_at16 got=%b exp=1", full); end
    wr(8'hEE, 1'b0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_after17 got=%b exp=1", full); end
`ifdef ROUTER_FIFO_OVF_FLAG_EN
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow); end
`endif
    read_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (data_out !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL full_read%0d got=%h exp=%h", i, data_out, 8'hA0 + 8'(i)); end
    end
    read_enb = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) wr(8'h50 + 8'(i), 1'b0);
    read_enb  = 1'b1;
    write_enb = 1'b1;
    data_in   = 8'h99;
    tick();
    write_enb = 1'b0;
    checks++; if (data_out !== 8'h50) begin failures++; $display("FAIL b2b_read got=%h exp=50", data_out); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", full); end
    // Remaining 15 entries must be 0x51..0x5F with nothing after them.
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++; if (data_out !== 8'h50 + 8'(i)) begin failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, data_out, 8'h50 + 8'(i)); end
    end
    read_enb = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    logic       we, re, rd_ok, wr_ok;
    for (int i = 0; i < 80; i++) begin
      we = (i < 60);
      re = (i < 20) ? (i % 2 == 1) : (i < 60) ? (i % 4 == 3) : 1'b1;
      write_enb = we;
      read_enb  = re;
      data_in   = 8'(i * 7 + 3);
      rd_ok = re && (q.size() > 0);
      wr_ok = we && (q.size() < 16);
      exp_d = 8'h00;
      if (rd_ok) exp_d = q.pop_front();
      if (wr_ok) q.push_back(data_in);
      tick();
      checks++; if (data_out !== exp_d) begin failures++; $display("FAIL wrap_data c%0d got=%h exp=%h", i, data_out, exp_d); end
      checks++; if (empty !== (q.size() == 0)) begin failures++; $display("FAIL wrap_empty c%0d got=%b exp=%b", i, empty, q.size() == 0); end
      checks++; if (full !== (q.size() == 16)) begin failures++; $display("FAIL wrap_full c%0d got=%b exp=%b", i, full, q.size() == 16); end
    end
    write_enb = 1'b0;
    read_enb  = 1'b0;
  endtask

  task automatic test_soft_reset();
    logic [7:0] exp [4];
    wr(8'h10, 1'b1);
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b0);
    wr(8'h03, 1'b0);
    wr(8'h04, 1'b0);
    wr(8'h44, 1'b0);
    read_enb = 1'b1;
    tick();
    checks++; if (data_out !== 8'h10) begin failures++; $display("FAIL srst_pre0 got=%h exp=10", data_out); end
    tick();
    tick();
    checks++; if (data_out !== 8'h02) begin failures++; $display("FAIL srst_pre2 got=%h exp=02", data_out); end
    read_enb   = 1'b0;
    soft_reset = 1'b1;
    write_enb  = 1'b1;
    data_in    = 8'h77;
    tick();
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL srst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL srst_full got=%b exp=0", full); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL srst_data got=%h exp=00", data_out); end
    checks++; if (dut.pkt_cnt !== 6'd0) begin failures++; $display("FAIL srst_pkt_cnt got=%0d exp=0", dut.pkt_cnt); end
`ifdef ROUTER_FIFO_OVF_FLAG_EN
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL srst_overflow got=%b exp=0", overflow); end
`endif
    exp = '{8'h08, 8'hAA, 8'hBB, 8'h11};
    wr(8'h08, 1'b1);
    wr(8'hAA, 1'b0);
    wr(8'hBB, 1'b0);
    wr(8'h11, 1'b0);
    read_enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (data_out !== exp[i]) begin failures++; $display("FAIL srst_new%0d got=%h exp=%h", i, data_out, exp[i]); end
    end
    read_enb = 1'b0;
    tick();
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL srst_new_idle got=%h exp=00", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL srst_new_empty got=%b exp=1", empty); end
  endtask

  task automatic test_async_reset();
    wr(8'h0C, 1'b1);
    wr(8'h11, 1'b0);
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    checks++; if (data_out !== 8'h0C) begin failures++; $display("FAIL arst_pre_data got=%h exp=0C", data_out); end
    // Assert reset mid-cycle, well away from any rising edge.
    #1;
    reset = 1'b1;
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL arst_data got=%h exp=00", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL arst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL arst_full got=%b exp=0", full); end
    reset = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL arst_post_empty got=%b exp=1", empty); end
  endtask

  initial begin
    reset      = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    read_enb   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_packet();
    test_full();
    test_back_to_back();
    test_wrap();
    test_soft_reset();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
